// File: rtl/minmax_pkg.sv
// Shared types and helpers for the min/max range scanner.
// Used by minmax_if / minmax_finder; optional min tracking is enabled with MINMAX_MIN_EN.
package minmax_pkg;

  // Widest data word the compare helper handles; callers extend operands to this width.
  localparam int unsigned CMP_W = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LATCH   = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Strict greater-than; operands must already be sign- or zero-extended to CMP_W.
  function automatic logic gt(input logic [CMP_W-1:0] a,
                              input logic [CMP_W-1:0] b,
                              input logic             signed_mode);
    logic res;
    if (signed_mode) res = ($signed(a) > $signed(b));
    else             res = (a > b);
    return res;
  endfunction

endpackage

// File: rtl/minmax_if.sv
// Request/result and memory-read bundle between a requester and minmax_finder.
// The min_val/min_addr fields exist only when MINMAX_MIN_EN is defined.
interface minmax_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] max_val;
  logic [ADDR_W-1:0] max_addr;

`ifdef MINMAX_MIN_EN
  logic [DATA_W-1:0] min_val;
  logic [ADDR_W-1:0] min_addr;

  modport master (
    output start, start_addr, end_addr, mem_rdata,
    input  mem_addr, busy, done, max_val, max_addr, min_val, min_addr
  );

  modport slave (
    input  start, start_addr, end_addr, mem_rdata,
    output mem_addr, busy, done, max_val, max_addr, min_val, min_addr
  );
`else
  modport master (
    output start, start_addr, end_addr, mem_rdata,
    input  mem_addr, busy, done, max_val, max_addr
  );

  modport slave (
    input  start, start_addr, end_addr, mem_rdata,
    output mem_addr, busy, done, max_val, max_addr
  );
`endif

endinterface

// File: rtl/minmax_ctrl.sv
// Sequencer for minmax_finder: walks FETCH/LATCH/COMPARE per element and
// raises a one-cycle done pulse once the last address has been compared.
module minmax_ctrl
  import minmax_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic mar_eq_last,
  output logic en_mar,
  output logic sel_mar,
  output logic en_mdr,
  output logic upd_en,
  output logic first,
  output logic busy,
  output logic done
);

  state_t state;

  // DONE spends one cycle arming done and one cycle presenting it, so start is
  // only looked at again in the cycle after the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      first <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            first <= 1'b1;
            busy  <= 1'b1;
          end
        end
        FETCH:   state <= LATCH;
        LATCH:   state <= COMPARE;
        COMPARE: begin
          first <= 1'b0;
          state <= mar_eq_last ? DONE : FETCH;
        end
        DONE: begin
          if (!done) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath strobes are plain decodes of the current state.
  assign sel_mar = (state == IDLE);
  assign en_mar  = ((state == IDLE) && start) || ((state == COMPARE) && !mar_eq_last);
  assign en_mdr  = (state == LATCH);
  assign upd_en  = (state == COMPARE);

endmodule

// File: rtl/minmax_finder.sv
// Scans an inclusive, wrapping address range of a sync-read memory and reports the
// largest value and its first address; MINMAX_MIN_EN adds the smallest value too.
module minmax_finder
  import minmax_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned SIGNED = 0
) (
  input  logic      clk,
  input  logic      reset,
  minmax_if.slave   bus
);

  localparam logic SGN = (SIGNED != 0);

  logic [ADDR_W-1:0] mar;
  logic [ADDR_W-1:0] last;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] max_q;
  logic [ADDR_W-1:0] max_addr_q;

  logic en_mar, sel_mar, en_mdr, upd_en, first, mar_eq_last;
  logic take_max;

  // Extend a data word to the helper's compare width according to the compare mode.
  function automatic logic [CMP_W-1:0] ext(input logic [DATA_W-1:0] x);
    logic [CMP_W-1:0] r;
    if (SGN) r = CMP_W'($signed(x));
    else     r = CMP_W'(x);
    return r;
  endfunction

  minmax_ctrl u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .start       (bus.start),
    .mar_eq_last (mar_eq_last),
    .en_mar      (en_mar),
    .sel_mar     (sel_mar),
    .en_mdr      (en_mdr),
    .upd_en      (upd_en),
    .first       (first),
    .busy        (bus.busy),
    .done        (bus.done)
  );

  assign mar_eq_last = (mar == last);
  assign take_max    = first || gt(ext(mdr), ext(max_q), SGN);

  // Address counter wraps naturally at 2**ADDR_W; last is captured with the start address.
  always_ff @(posedge clk) begin
    if (reset) begin
      mar        <= '0;
      last       <= '0;
      mdr        <= '0;
      max_q      <= '0;
      max_addr_q <= '0;
    end else begin
      if (en_mar) begin
        mar <= sel_mar ? bus.start_addr : ADDR_W'(mar + 1'b1);
        if (sel_mar) last <= bus.end_addr;
      end
      if (en_mdr) mdr <= bus.mem_rdata;
      if (upd_en && take_max) begin
        max_q      <= mdr;
        max_addr_q <= mar;
      end
    end
  end

  assign bus.mem_addr = mar;
  assign bus.max_val  = max_q;
  assign bus.max_addr = max_addr_q;

`ifdef MINMAX_MIN_EN
  logic [DATA_W-1:0] min_q;
  logic [ADDR_W-1:0] min_addr_q;
  logic              take_min;

  assign take_min = first || gt(ext(min_q), ext(mdr), SGN);

  // Minimum tracker mirrors the maximum one with the operands swapped.
  always_ff @(posedge clk) begin
    if (reset) begin
      min_q      <= '0;
      min_addr_q <= '0;
    end else if (upd_en && take_min) begin
      min_q      <= mdr;
      min_addr_q <= mar;
    end
  end

  assign bus.min_val  = min_q;
  assign bus.min_addr = min_addr_q;
`endif

endmodule

// File: tb/tb_minmax_finder.sv
// Directed bench for minmax_finder (unsigned and signed instances) with a result scoreboard.
// Extra min checks are compiled in when MINMAX_MIN_EN is defined.
module tb_minmax_finder;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  typedef struct {
    logic [7:0] mx;
    logic [3:0] mxa;
    logic [7:0] mn;
    logic [3:0] mna;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  minmax_if #(.DATA_W(DW), .ADDR_W(AW)) if_u ();
  minmax_if #(.DATA_W(DW), .ADDR_W(AW)) if_s ();

  minmax_finder #(.DATA_W(DW), .ADDR_W(AW), .SIGNED(0)) u_dut_u (
    .clk(clk), .reset(reset), .bus(if_u.slave));
  minmax_finder #(.DATA_W(DW), .ADDR_W(AW), .SIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .bus(if_s.slave));

  logic [7:0] mem_u [16];
  logic [7:0] mem_s [16];

  // Synchronous-read memories: data appears the cycle after the address.
  always @(posedge clk) begin
    if_u.mem_rdata <= mem_u[if_u.mem_addr];
    if_s.mem_rdata <= mem_s[if_s.mem_addr];
  end

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   sel = 1'b0;

  wire       obs_done  = sel ? if_s.done     : if_u.done;
  wire       obs_busy  = sel ? if_s.busy     : if_u.busy;
  wire [7:0] obs_max   = sel ? if_s.max_val  : if_u.max_val;
  wire [3:0] obs_maxa  = sel ? if_s.max_addr : if_u.max_addr;
  wire [3:0] obs_maddr = sel ? if_s.mem_addr : if_u.mem_addr;
`ifdef MINMAX_MIN_EN
  wire [7:0] obs_min   = sel ? if_s.min_val  : if_u.min_val;
  wire [3:0] obs_mina  = sel ? if_s.min_addr : if_u.min_addr;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference scan over the bench's own copy of memory.
  function automatic exp_t model(input bit sgn, input logic [3:0] s, input logic [3:0] e);
    exp_t       r;
    logic [3:0] d;
    logic [3:0] a;
    logic [7:0] v;
    bit         hi, lo;
    int         n;
    d = e - s;
    n = int'(d) + 1;
    a = s;
    r.mx = '0; r.mxa = '0; r.mn = '0; r.mna = '0;
    for (int i = 0; i < n; i++) begin
      v = sgn ? mem_s[a] : mem_u[a];
      if (sgn) begin
        hi = ($signed(v) > $signed(r.mx));
        lo = ($signed(v) < $signed(r.mn));
      end else begin
        hi = (v > r.mx);
        lo = (v < r.mn);
      end
      if (i == 0 || hi) begin r.mx = v; r.mxa = a; end
      if (i == 0 || lo) begin r.mn = v; r.mna = a; end
      a = a + 4'd1;
    end
    r.lat = 3 * n + 1;
    return r;
  endfunction

  task automatic drive_start(input bit s_sel, input logic [3:0] sa, input logic [3:0] ea,
                             input logic v);
    if (s_sel) begin
      if_s.start = v; if_s.start_addr = sa; if_s.end_addr = ea;
    end else begin
      if_u.start = v; if_u.start_addr = sa; if_u.end_addr = ea;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_addr"}, 32'(obs_maddr), 32'd0);
    chk({tag, "_busy"},     32'(obs_busy),  32'd0);
    chk({tag, "_done"},     32'(obs_done),  32'd0);
    chk({tag, "_max_val"},  32'(obs_max),   32'd0);
    chk({tag, "_max_addr"}, 32'(obs_maxa),  32'd0);
`ifdef MINMAX_MIN_EN
    chk({tag, "_min_val"},  32'(obs_min),   32'd0);
    chk({tag, "_min_addr"}, 32'(obs_mina),  32'd0);
`endif
  endtask

  // One scan; pulse_cyc>0 re-asserts start (other addresses) that many cycles in.
  task automatic run(input bit s_sel, input logic [3:0] sa, input logic [3:0] ea,
                     input int pulse_cyc, input string tag);
    exp_t y;
    int   cyc;
    bit   got;
    sel = s_sel;
    sb.push_back(model(s_sel, sa, ea));
    drive_start(s_sel, sa, ea, 1'b1);
    @(posedge clk); #1;
    drive_start(s_sel, sa, ea, 1'b0);
    chk({tag, "_busy_on"}, 32'(obs_busy), 32'd1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      if (pulse_cyc != 0 && cyc == pulse_cyc) drive_start(s_sel, sa + 4'd8, sa + 4'd8, 1'b1);
      @(posedge clk); #1;
      drive_start(s_sel, sa, ea, 1'b0);
      cyc++;
      got = obs_done;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    y = sb.pop_front();
    chk({tag, "_latency"},  32'(cyc),      32'(y.lat));
    chk({tag, "_max_val"},  32'(obs_max),  32'(y.mx));
    chk({tag, "_max_addr"}, 32'(obs_maxa), 32'(y.mxa));
`ifdef MINMAX_MIN_EN
    chk({tag, "_min_val"},  32'(obs_min),  32'(y.mn));
    chk({tag, "_min_addr"}, 32'(obs_mina), 32'(y.mna));
`endif
    chk({tag, "_busy_off"}, 32'(obs_busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(obs_done), 32'd0);
    chk({tag, "_max_hold"},   32'(obs_max),  32'(y.mx));
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    drive_start(1'b0, 4'd0, 4'd0, 1'b0);
    drive_start(1'b1, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      mem_u[i] = 8'h00;
      mem_s[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; #0 chk_zero("rst_u");
    sel = 1'b1; #0 chk_zero("rst_s");
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic unsigned scan with a repeated maximum.
    mem_u[0] = 8'd3; mem_u[1] = 8'd9; mem_u[2] = 8'd2; mem_u[3] = 8'd9;
    run(1'b0, 4'd0, 4'd3, 0, "t1");

    // Wrapping range 14..1; a larger value outside the range must be ignored.
    mem_u[14] = 8'h10; mem_u[15] = 8'h20; mem_u[0] = 8'h7F; mem_u[1] = 8'h05;
    mem_u[5]  = 8'hFF;
    run(1'b0, 4'd14, 4'd1, 0, "t3");

    // Single element of value zero.
    mem_u[7] = 8'h00;
    run(1'b0, 4'd7, 4'd7, 0, "t4");

    // Start pulsed mid-scan is ignored.
    run(1'b0, 4'd0, 4'd3, 4, "t5_pulse");

    // Reset during COMPARE aborts without a done pulse.
    sel = 1'b0;
    drive_start(1'b0, 4'd0, 4'd3, 1'b1);
    @(posedge clk); #1;
    drive_start(1'b0, 4'd0, 4'd3, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_zero("t5_rst");
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      seen = seen | obs_done;
    end
    chk("t5_no_done", 32'(seen), 32'd0);
    run(1'b0, 4'd0, 4'd3, 0, "t5_after");

    // Full range of identical words: first address wins.
    for (int i = 0; i < 16; i++) mem_u[i] = 8'h55;
    run(1'b0, 4'd0, 4'd15, 0, "t6");

    // Signed: all-negative data, max seeded from the first element.
    mem_s[4] = 8'hFB; mem_s[5] = 8'hFE; mem_s[6] = 8'hF9;
    run(1'b1, 4'd4, 4'd6, 0, "t2");

    // Signed ordering differs from unsigned: 0x80 is the minimum, 0x7F the maximum.
    mem_s[0] = 8'h7F; mem_s[1] = 8'h80; mem_s[2] = 8'h01;
    run(1'b1, 4'd0, 4'd2, 0, "t2b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
